// File: rtl/ras_circ_ckpt_if.sv
// Port bundle for the return-address stack.
// The predecode and controller side (master) drives the request and control
// strobes. The stack (slave) returns top-of-stack, occupancy and event pulses.
// There is no valid/ready handshake: every input is sampled on every rising
// edge, and the stack never stalls its producer.
interface ras_circ_ckpt_if #(
  parameter int VLEN  = 64,
  parameter int PTR_W = 1
);
  logic            flush_i;
  logic            push_i;
  logic            pop_i;
  logic [VLEN-1:0] data_i;
  logic            ckpt_i;
  logic            restore_i;
  logic [VLEN-1:0] data_o;
  logic            valid_o;
  logic [PTR_W:0]  count_o;
  logic            overflow_o;
  logic            underflow_o;

  modport master (
    output flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
    input  data_o, valid_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, pop_i, data_i, ckpt_i, restore_i,
    output data_o, valid_o, count_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/ras_circ_ckpt.sv
// Circular return-address stack with a single pointer checkpoint.
// A push onto a full stack overwrites the oldest entry. A push and a pop in
// the same cycle replace the top entry (coroutine). The checkpoint slot
// saves {tos,count} so the pointers can be recovered after a mispredict.
module ras_circ_ckpt #(
  parameter int VLEN  = 64,
  parameter int DEPTH = 2,
  localparam int PTR_W = $clog2(DEPTH > 1 ? DEPTH : 2)
) (
  input logic           clk_i,
  input logic           rst_ni,
  ras_circ_ckpt_if.slave bus
);

  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);

  logic [VLEN-1:0]  mem_q [DEPTH];
  logic [VLEN-1:0]  mem_d [DEPTH];
  logic [PTR_W-1:0] tos_q, tos_d;
  logic [PTR_W:0]   count_q, count_d;
  logic [PTR_W-1:0] ckpt_tos_q, ckpt_tos_d;
  logic [PTR_W:0]   ckpt_count_q, ckpt_count_d;
  logic             overflow_q, overflow_d;
  logic             underflow_q, underflow_d;

  logic [PTR_W-1:0] tos_inc, tos_dec;
  logic             wr_en;
  logic [PTR_W-1:0] wr_idx;
  logic [VLEN-1:0]  rd_data;

  // Wrap-around pointer arithmetic without modulo, so any depth is legal.
  always_comb begin
    tos_inc = (tos_q == LAST_IDX) ? '0 : tos_q + 1'b1;
    tos_dec = (tos_q == '0) ? LAST_IDX : tos_q - 1'b1;
  end

  // Zero-latency top-of-stack read.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (tos_q == PTR_W'(i)) rd_data = mem_q[i];
    end
  end

  // Next-state: flush beats restore beats push/pop; checkpoint capture is independent.
  always_comb begin
    tos_d        = tos_q;
    count_d      = count_q;
    overflow_d   = 1'b0;
    underflow_d  = 1'b0;
    wr_en        = 1'b0;
    wr_idx       = tos_q;
    // The slot always takes the pre-update live pointers, so a same-cycle
    // restore still reads the old slot contents.
    ckpt_tos_d   = bus.ckpt_i ? tos_q   : ckpt_tos_q;
    ckpt_count_d = bus.ckpt_i ? count_q : ckpt_count_q;

    if (bus.flush_i) begin
      tos_d   = '0;
      count_d = '0;
    end else if (bus.restore_i) begin
      tos_d   = ckpt_tos_q;
      count_d = ckpt_count_q;
    end else if (bus.push_i && bus.pop_i && (count_q != '0)) begin
      wr_en  = 1'b1;
      wr_idx = tos_q;
    end else if (bus.push_i) begin
      // Also covers push+pop on an empty stack: behaves as a plain push.
      wr_en  = 1'b1;
      wr_idx = tos_inc;
      tos_d  = tos_inc;
      if (count_q == FULL_CNT) overflow_d = 1'b1;
      else                     count_d    = count_q + 1'b1;
    end else if (bus.pop_i) begin
      if (count_q != '0) begin
        tos_d   = tos_dec;
        count_d = count_q - 1'b1;
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // Entry write path.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
      if (wr_en && (wr_idx == PTR_W'(i))) mem_d[i] = bus.data_i;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      tos_q        <= '0;
      count_q      <= '0;
      ckpt_tos_q   <= '0;
      ckpt_count_q <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      tos_q        <= tos_d;
      count_q      <= count_d;
      ckpt_tos_q   <= ckpt_tos_d;
      ckpt_count_q <= ckpt_count_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
    end
  end

  // Output mapping.
  always_comb begin
    bus.data_o      = rd_data;
    bus.valid_o     = (count_q != '0);
    bus.count_o     = count_q;
    bus.overflow_o  = overflow_q;
    bus.underflow_o = underflow_q;
  end

endmodule

// File: tb/tb_ras_circ_ckpt.sv
// Directed bench for the circular return-address stack, DEPTH 1, 2 and 3.
module tb_ras_circ_ckpt;

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  ras_circ_ckpt_if #(.VLEN(64), .PTR_W(1)) i1 ();
  ras_circ_ckpt_if #(.VLEN(64), .PTR_W(1)) i2 ();
  ras_circ_ckpt_if #(.VLEN(64), .PTR_W(2)) i3 ();

  ras_circ_ckpt #(.VLEN(64), .DEPTH(1)) u_d1 (.clk_i(clk), .rst_ni(rst_n), .bus(i1));
  ras_circ_ckpt #(.VLEN(64), .DEPTH(2)) u_d2 (.clk_i(clk), .rst_ni(rst_n), .bus(i2));
  ras_circ_ckpt #(.VLEN(64), .DEPTH(3)) u_d3 (.clk_i(clk), .rst_ni(rst_n), .bus(i3));

  // Clock and reset defaults
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_all();
    {i1.flush_i, i1.push_i, i1.pop_i, i1.ckpt_i, i1.restore_i} = '0; i1.data_i = '0;
    {i2.flush_i, i2.push_i, i2.pop_i, i2.ckpt_i, i2.restore_i} = '0; i2.data_i = '0;
    {i3.flush_i, i3.push_i, i3.pop_i, i3.ckpt_i, i3.restore_i} = '0; i3.data_i = '0;
  endtask

  // Driver: apply one cycle of control to the selected stack, then sample #1 after the edge.
  task automatic op(input int sel, input logic fl, input logic pu, input logic po,
                    input logic ck, input logic rs, input logic [63:0] d);
    idle_all();
    case (sel)
      1: begin i1.flush_i = fl; i1.push_i = pu; i1.pop_i = po; i1.ckpt_i = ck; i1.restore_i = rs; i1.data_i = d; end
      2: begin i2.flush_i = fl; i2.push_i = pu; i2.pop_i = po; i2.ckpt_i = ck; i2.restore_i = rs; i2.data_i = d; end
      default: begin i3.flush_i = fl; i3.push_i = pu; i3.pop_i = po; i3.ckpt_i = ck; i3.restore_i = rs; i3.data_i = d; end
    endcase
    @(posedge clk); #1;
    idle_all();
  endtask

  task automatic push(input int sel, input logic [63:0] d); op(sel, 0, 1, 0, 0, 0, d); endtask
  task automatic pop(input int sel);                         op(sel, 0, 0, 1, 0, 0, '0); endtask
  task automatic idle(input int sel);                        op(sel, 0, 0, 0, 0, 0, '0); endtask

  task automatic test_reset();
    idle_all();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);
    n_vec++; if (i2.data_o !== 64'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", i2.data_o); end
    n_vec++; if (i2.valid_o !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", i2.valid_o); end
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", i2.count_o); end
    n_vec++; if (i2.overflow_o !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b want 0", i2.overflow_o); end
    n_vec++; if (i2.underflow_o !== 1'b0) begin n_err++; $display("FAIL reset_unf: got %b want 0", i2.underflow_o); end
    n_vec++; if (i3.count_o !== 3'd0 || i3.data_o !== 64'h0) begin n_err++; $display("FAIL reset_d3: got cnt %0d data %h want 0/0", i3.count_o, i3.data_o); end
  endtask

  task automatic test_push_pop();
    push(2, 64'h1000);
    push(2, 64'h2000);
    n_vec++; if (i2.data_o !== 64'h2000) begin n_err++; $display("FAIL pp_top2: got %h want 2000", i2.data_o); end
    n_vec++; if (i2.count_o !== 2'd2) begin n_err++; $display("FAIL pp_cnt2: got %0d want 2", i2.count_o); end
    pop(2);
    n_vec++; if (i2.data_o !== 64'h1000) begin n_err++; $display("FAIL pp_top1: got %h want 1000", i2.data_o); end
    n_vec++; if (i2.count_o !== 2'd1) begin n_err++; $display("FAIL pp_cnt1: got %0d want 1", i2.count_o); end
    pop(2);
    n_vec++; if (i2.valid_o !== 1'b0) begin n_err++; $display("FAIL pp_empty_valid: got %b want 0", i2.valid_o); end
    n_vec++; if (i2.underflow_o !== 1'b0) begin n_err++; $display("FAIL pp_no_unf: got %b want 0", i2.underflow_o); end
    pop(2);
    n_vec++; if (i2.underflow_o !== 1'b1) begin n_err++; $display("FAIL pp_unf: got %b want 1", i2.underflow_o); end
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL pp_unf_cnt: got %0d want 0", i2.count_o); end
    idle(2);
    n_vec++; if (i2.underflow_o !== 1'b0) begin n_err++; $display("FAIL pp_unf_clear: got %b want 0", i2.underflow_o); end
  endtask

  task automatic test_overflow();
    push(2, 64'h10);
    push(2, 64'h20);
    n_vec++; if (i2.overflow_o !== 1'b0) begin n_err++; $display("FAIL ov_early: got %b want 0", i2.overflow_o); end
    push(2, 64'h30);
    n_vec++; if (i2.count_o !== 2'd2) begin n_err++; $display("FAIL ov_cnt: got %0d want 2", i2.count_o); end
    n_vec++; if (i2.overflow_o !== 1'b1) begin n_err++; $display("FAIL ov_pulse: got %b want 1", i2.overflow_o); end
    n_vec++; if (i2.data_o !== 64'h30) begin n_err++; $display("FAIL ov_top: got %h want 30", i2.data_o); end
    idle(2);
    n_vec++; if (i2.overflow_o !== 1'b0) begin n_err++; $display("FAIL ov_clear: got %b want 0", i2.overflow_o); end
    pop(2);
    n_vec++; if (i2.data_o !== 64'h20) begin n_err++; $display("FAIL ov_pop1: got %h want 20", i2.data_o); end
    pop(2);
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL ov_pop2: got %0d want 0", i2.count_o); end
  endtask

  task automatic test_coroutine();
    push(2, 64'h40);
    push(2, 64'h50);
    op(2, 0, 1, 1, 0, 0, 64'h60);
    n_vec++; if (i2.count_o !== 2'd2) begin n_err++; $display("FAIL co_cnt: got %0d want 2", i2.count_o); end
    n_vec++; if (i2.data_o !== 64'h60) begin n_err++; $display("FAIL co_top: got %h want 60", i2.data_o); end
    n_vec++; if (i2.overflow_o !== 1'b0) begin n_err++; $display("FAIL co_no_ovf: got %b want 0", i2.overflow_o); end
    pop(2);
    n_vec++; if (i2.data_o !== 64'h40) begin n_err++; $display("FAIL co_pop: got %h want 40", i2.data_o); end
    pop(2);
    op(2, 0, 1, 1, 0, 0, 64'h70);
    n_vec++; if (i2.count_o !== 2'd1 || i2.data_o !== 64'h70) begin n_err++; $display("FAIL co_empty: got cnt %0d data %h want 1/70", i2.count_o, i2.data_o); end
    n_vec++; if (i2.underflow_o !== 1'b0) begin n_err++; $display("FAIL co_empty_unf: got %b want 0", i2.underflow_o); end
    pop(2);
  endtask

  task automatic test_checkpoint();
    push(2, 64'hA0);
    op(2, 0, 0, 0, 1, 0, '0);
    push(2, 64'hB0);
    pop(2);
    pop(2);
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL ck_drained: got %0d want 0", i2.count_o); end
    op(2, 0, 0, 0, 0, 1, '0);
    n_vec++; if (i2.count_o !== 2'd1) begin n_err++; $display("FAIL ck_restore_cnt: got %0d want 1", i2.count_o); end
    n_vec++; if (i2.data_o !== 64'hA0) begin n_err++; $display("FAIL ck_restore_top: got %h want a0", i2.data_o); end
    // restore with a push in the same cycle: push is ignored
    op(2, 0, 1, 0, 0, 1, 64'hEE);
    n_vec++; if (i2.count_o !== 2'd1 || i2.data_o !== 64'hA0) begin n_err++; $display("FAIL ck_restore_push: got cnt %0d data %h want 1/a0", i2.count_o, i2.data_o); end
    op(2, 1, 0, 0, 0, 1, '0);
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL ck_flush_wins: got %0d want 0", i2.count_o); end
    // ckpt+restore: restore reads the old slot, slot takes the empty pointers
    op(2, 0, 0, 0, 1, 1, '0);
    n_vec++; if (i2.count_o !== 2'd1 || i2.data_o !== 64'hA0) begin n_err++; $display("FAIL ck_both: got cnt %0d data %h want 1/a0", i2.count_o, i2.data_o); end
    op(2, 0, 0, 0, 0, 1, '0);
    n_vec++; if (i2.count_o !== 2'd0) begin n_err++; $display("FAIL ck_slot_new: got %0d want 0", i2.count_o); end
    push(2, 64'hC0);
    op(2, 1, 1, 0, 0, 0, 64'hD0);
    n_vec++; if (i2.valid_o !== 1'b0 || i2.overflow_o !== 1'b0) begin n_err++; $display("FAIL flush_push: got valid %b ovf %b want 0/0", i2.valid_o, i2.overflow_o); end
  endtask

  task automatic test_depth1();
    push(1, 64'h5);
    n_vec++; if (i1.count_o !== 2'd1 || i1.overflow_o !== 1'b0) begin n_err++; $display("FAIL d1_push: got cnt %0d ovf %b want 1/0", i1.count_o, i1.overflow_o); end
    push(1, 64'h6);
    n_vec++; if (i1.count_o !== 2'd1 || i1.data_o !== 64'h6) begin n_err++; $display("FAIL d1_over: got cnt %0d data %h want 1/6", i1.count_o, i1.data_o); end
    n_vec++; if (i1.overflow_o !== 1'b1) begin n_err++; $display("FAIL d1_ovf: got %b want 1", i1.overflow_o); end
    pop(1);
    n_vec++; if (i1.count_o !== 2'd0) begin n_err++; $display("FAIL d1_pop: got %0d want 0", i1.count_o); end
  endtask

  task automatic test_depth3();
    logic [63:0] exp_top [3];
    exp_top[0] = 64'h7; exp_top[1] = 64'h6; exp_top[2] = 64'h5;
    for (int i = 1; i <= 7; i++) push(3, 64'(i));
    n_vec++; if (i3.data_o !== 64'h7) begin n_err++; $display("FAIL d3_top: got %h want 7", i3.data_o); end
    n_vec++; if (i3.count_o !== 3'd3) begin n_err++; $display("FAIL d3_cnt: got %0d want 3", i3.count_o); end
    n_vec++; if (i3.overflow_o !== 1'b1) begin n_err++; $display("FAIL d3_ovf: got %b want 1", i3.overflow_o); end
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (i3.data_o !== exp_top[i]) begin n_err++; $display("FAIL d3_pop%0d: got %h want %h", i, i3.data_o, exp_top[i]); end
      pop(3);
    end
    n_vec++; if (i3.count_o !== 3'd0) begin n_err++; $display("FAIL d3_empty: got %0d want 0", i3.count_o); end
    push(3, 64'h9);
    op(3, 0, 1, 0, 1, 0, 64'h8);
    // reset mid-stream with a push pending
    i3.push_i = 1'b1; i3.data_i = 64'h77; rst_n = 1'b0;
    @(posedge clk); #1;
    idle_all(); rst_n = 1'b1;
    n_vec++; if (i3.count_o !== 3'd0 || i3.valid_o !== 1'b0 || i3.data_o !== 64'h0) begin n_err++; $display("FAIL d3_rst: got cnt %0d valid %b data %h want 0/0/0", i3.count_o, i3.valid_o, i3.data_o); end
    n_vec++; if (i3.overflow_o !== 1'b0 || i3.underflow_o !== 1'b0) begin n_err++; $display("FAIL d3_rst_pulse: got ovf %b unf %b want 0/0", i3.overflow_o, i3.underflow_o); end
    op(3, 0, 0, 0, 0, 1, '0);
    n_vec++; if (i3.count_o !== 3'd0) begin n_err++; $display("FAIL d3_rst_ckpt: got %0d want 0", i3.count_o); end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    idle_all();
    test_reset();
    test_push_pop();
    test_overflow();
    test_coroutine();
    test_checkpoint();
    test_depth1();
    test_depth3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
